// File: rtl/ps2_game_input.sv
// PS/2 keyboard receiver and scancode decoder producing held-key move/shoot
// controls for two players of the tank game.
module ps2_game_input #(
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [3:0] player_1_move_o,
  output logic [3:0] player_2_move_o,
  output logic       player_1_shoot_o,
  output logic       player_2_shoot_o,
  output logic [7:0] scancode_o,
  output logic       scancode_valid_o,
  output logic       frame_error_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned NKEYS = 10;
  localparam int unsigned KW = 4;

  // Held-key indices
  localparam logic [KW-1:0] P1_UP    = KW'(0);
  localparam logic [KW-1:0] P1_DOWN  = KW'(1);
  localparam logic [KW-1:0] P1_LEFT  = KW'(2);
  localparam logic [KW-1:0] P1_RIGHT = KW'(3);
  localparam logic [KW-1:0] P1_SHOOT = KW'(4);
  localparam logic [KW-1:0] P2_UP    = KW'(5);
  localparam logic [KW-1:0] P2_DOWN  = KW'(6);
  localparam logic [KW-1:0] P2_LEFT  = KW'(7);
  localparam logic [KW-1:0] P2_RIGHT = KW'(8);
  localparam logic [KW-1:0] P2_SHOOT = KW'(9);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall;
  state_t        state;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift_q;
  logic [TW-1:0] to_cnt;
  logic          frame_ok;
  logic          ext_q, brk_q;
  logic [NKEYS-1:0] held_q;
  logic          key_hit;
  logic [KW-1:0] key_idx;

  // Two-flop synchronisers; idle bus level after reset avoids a false fall
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_i;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_i;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // At the stop-bit fall, shift_q holds data[7:0] and parity[8]
  assign frame_ok = (^shift_q) & data_s2;

  // Frame receiver; the timeout check has priority over a coincident fall
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state            <= IDLE;
      bit_cnt          <= 4'd0;
      shift_q          <= 9'd0;
      to_cnt           <= '0;
      scancode_o       <= 8'h00;
      scancode_valid_o <= 1'b0;
      frame_error_o    <= 1'b0;
    end else begin
      scancode_valid_o <= 1'b0;
      frame_error_o    <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            if (!data_s2) begin
              state   <= RECV;
              bit_cnt <= 4'd1;
              to_cnt  <= '0;
            end else begin
              frame_error_o <= 1'b1;
            end
          end
        end
        RECV: begin
          if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
            state         <= IDLE;
            bit_cnt       <= 4'd0;
            frame_error_o <= 1'b1;
          end else if (fall) begin
            to_cnt  <= '0;
            shift_q <= {data_s2, shift_q[8:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd10) begin
              state <= CHECK;
              if (frame_ok) begin
                scancode_o       <= shift_q[7:0];
                scancode_valid_o <= 1'b1;
              end else begin
                frame_error_o <= 1'b1;
              end
            end
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        CHECK: begin
          state   <= IDLE;
          bit_cnt <= 4'd0;
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Key map lookup on (ext, code); numpad codes without E0 do not match
  always_comb begin
    key_hit = 1'b1;
    key_idx = P1_UP;
    case ({ext_q, scancode_o})
      9'h01D:  key_idx = P1_UP;
      9'h01B:  key_idx = P1_DOWN;
      9'h01C:  key_idx = P1_LEFT;
      9'h023:  key_idx = P1_RIGHT;
      9'h029:  key_idx = P1_SHOOT;
      9'h175:  key_idx = P2_UP;
      9'h172:  key_idx = P2_DOWN;
      9'h16B:  key_idx = P2_LEFT;
      9'h174:  key_idx = P2_RIGHT;
      9'h05A:  key_idx = P2_SHOOT;
      default: key_hit = 1'b0;
    endcase
  end

  // Prefix tracking and held-key state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      held_q <= '0;
    end else if (frame_error_o) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (scancode_valid_o) begin
      if (scancode_o == 8'hE0) begin
        ext_q <= 1'b1;
      end else if (scancode_o == 8'hF0) begin
        brk_q <= 1'b1;
      end else begin
        if (key_hit) begin
          held_q[key_idx] <= ~brk_q;
        end
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  // Opposing directions held together cancel each other
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      player_1_move_o  <= 4'b0000;
      player_2_move_o  <= 4'b0000;
      player_1_shoot_o <= 1'b0;
      player_2_shoot_o <= 1'b0;
    end else begin
      player_1_move_o  <= {held_q[P1_LEFT] & ~held_q[P1_RIGHT],
                           held_q[P1_RIGHT] & ~held_q[P1_LEFT],
                           held_q[P1_UP] & ~held_q[P1_DOWN],
                           held_q[P1_DOWN] & ~held_q[P1_UP]};
      player_2_move_o  <= {held_q[P2_LEFT] & ~held_q[P2_RIGHT],
                           held_q[P2_RIGHT] & ~held_q[P2_LEFT],
                           held_q[P2_UP] & ~held_q[P2_DOWN],
                           held_q[P2_DOWN] & ~held_q[P2_UP]};
      player_1_shoot_o <= held_q[P1_SHOOT];
      player_2_shoot_o <= held_q[P2_SHOOT];
    end
  end

endmodule

// File: tb/tb_ps2_game_input.sv
// Bench for ps2_game_input: serial PS/2 frames against a key-event model.
module tb_ps2_game_input;

  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] p1_move, p2_move;
  logic       p1_shoot, p2_shoot;
  logic [7:0] scancode;
  logic       scancode_valid, frame_error;

  always #5 clk = ~clk;

  ps2_game_input #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .ps2_clk_i        (ps2_clk),
    .ps2_data_i       (ps2_data),
    .player_1_move_o  (p1_move),
    .player_2_move_o  (p2_move),
    .player_1_shoot_o (p1_shoot),
    .player_2_shoot_o (p2_shoot),
    .scancode_o       (scancode),
    .scancode_valid_o (scancode_valid),
    .frame_error_o    (frame_error)
  );

  // {p1_move, p2_move, p1_shoot, p2_shoot}
  logic [9:0] outs;
  assign outs = {p1_move, p2_move, p1_shoot, p2_shoot};

  int total = 0;
  int bad = 0;

  // Monitor: pulse counters and output snapshots 1 and 2 cycles after each valid
  int         valid_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] last_code = 8'h00;
  logic [9:0] snap1 = '0;
  logic [9:0] snap2 = '0;
  int         snap_k = 0;
  logic       prev_valid = 1'b0;
  logic       wide = 1'b0;

  always @(negedge clk) begin
    prev_valid <= scancode_valid;
    if (scancode_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_code <= scancode;
      snap_k    <= 1;
      if (prev_valid) wide <= 1'b1;
    end else if (snap_k == 1) begin
      snap1  <= outs;
      snap_k <= 2;
    end else if (snap_k == 2) begin
      snap2  <= outs;
      snap_k <= 0;
    end
    if (frame_error) err_cnt <= err_cnt + 1;
  end

  // Model: keys 0..9 = P1 up,down,left,right,shoot, P2 up,down,left,right,shoot
  logic       key_ext  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
  logic [7:0] key_code [10] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29,
                                8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
  logic [9:0] model_held = '0;
  logic [9:0] prev_exp = '0;

  function automatic logic [9:0] exp_outs(input logic [9:0] h);
    exp_outs = {h[2] & ~h[3], h[3] & ~h[2], h[0] & ~h[1], h[1] & ~h[0],
                h[7] & ~h[8], h[8] & ~h[7], h[5] & ~h[6], h[6] & ~h[5],
                h[4], h[9]};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(4);
    ps2_clk = 1'b0;
    wait_cyc(8);
    ps2_clk = 1'b1;
    wait_cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] c, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(c[i]);
    send_bit((~^c) ^ bad_par);
    send_bit(~bad_stop);
    wait_cyc(4);
  endtask

  task automatic key_event(input logic ext, input logic brk, input logic [7:0] code);
    prev_exp = exp_outs(model_held);
    if (ext) send_byte(8'hE0, 1'b0, 1'b0);
    if (brk) send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(code, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      if (key_ext[k] == ext && key_code[k] == code) model_held[k] = ~brk;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    wait_cyc(3);
    reset_i = 1'b0;
    wait_cyc(3);
    total++;
    if ({outs, scancode, scancode_valid, frame_error} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs: got=%h want=0", {outs, scancode, scancode_valid, frame_error});
    end
    total++;
    if (valid_cnt !== 0 || err_cnt !== 0) begin
      bad++;
      $display("FAIL reset_no_pulse: valid=%0d err=%0d want 0/0", valid_cnt, err_cnt);
    end
  endtask

  task automatic test_make;
    int v0;
    v0 = valid_cnt;
    key_event(1'b0, 1'b0, 8'h1D);
    total++;
    if (valid_cnt !== v0 + 1 || last_code !== 8'h1D || wide !== 1'b0) begin
      bad++;
      $display("FAIL make_valid: count=%0d code=%h wide=%b want %0d/1d/0", valid_cnt - v0, last_code, wide, 1);
    end
    total++;
    if (snap1 !== prev_exp) begin
      bad++;
      $display("FAIL make_latency1: outs=%b want=%b", snap1, prev_exp);
    end
    total++;
    if (snap2[9:6] !== 4'b0010 || snap2 !== exp_outs(model_held)) begin
      bad++;
      $display("FAIL make_latency2: outs=%b want=%b", snap2, exp_outs(model_held));
    end
  endtask

  task automatic test_extended;
    key_event(1'b0, 1'b1, 8'h1D);
    total++;
    if (outs !== 10'd0) begin
      bad++;
      $display("FAIL release_w: outs=%b want=0", outs);
    end
    key_event(1'b1, 1'b0, 8'h75);
    total++;
    if (p2_move !== 4'b0010 || p1_move !== 4'b0000 || snap1 !== prev_exp) begin
      bad++;
      $display("FAIL ext_up_make: p2=%b p1=%b snap1=%b want 0010/0000/%b", p2_move, p1_move, snap1, prev_exp);
    end
    key_event(1'b1, 1'b1, 8'h75);
    total++;
    if (p2_move !== 4'b0000 || p1_move !== 4'b0000) begin
      bad++;
      $display("FAIL ext_up_break: p2=%b p1=%b want 0000/0000", p2_move, p1_move);
    end
    key_event(1'b0, 1'b0, 8'h75);
    total++;
    if (outs !== 10'd0) begin
      bad++;
      $display("FAIL numpad_decoy: outs=%b want=0", outs);
    end
  endtask

  task automatic test_cancel;
    key_event(1'b0, 1'b0, 8'h1C);
    key_event(1'b0, 1'b0, 8'h23);
    total++;
    if (p1_move !== 4'b0000) begin
      bad++;
      $display("FAIL lr_cancel: p1=%b want=0000", p1_move);
    end
    key_event(1'b0, 1'b1, 8'h1C);
    total++;
    if (p1_move !== 4'b0100 || outs !== exp_outs(model_held)) begin
      bad++;
      $display("FAIL lr_release: p1=%b want=0100", p1_move);
    end
  endtask

  task automatic test_parity;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_byte(8'h29, 1'b1, 1'b0);
    total++;
    if (err_cnt !== e0 + 1 || valid_cnt !== v0 || p1_shoot !== 1'b0) begin
      bad++;
      $display("FAIL bad_parity: err=%0d valid=%0d shoot=%b want 1/0/0", err_cnt - e0, valid_cnt - v0, p1_shoot);
    end
    key_event(1'b0, 1'b0, 8'h29);
    total++;
    if (p1_shoot !== 1'b1) begin
      bad++;
      $display("FAIL shoot_after_err: shoot=%b want=1", p1_shoot);
    end
    e0 = err_cnt;
    prev_exp = exp_outs(model_held);
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b0, 1'b1);
    send_byte(8'h75, 1'b0, 1'b0);
    total++;
    if (err_cnt !== e0 + 1 || outs !== prev_exp) begin
      bad++;
      $display("FAIL stop_err_clears_ext: err=%0d outs=%b want 1/%b", err_cnt - e0, outs, prev_exp);
    end
  endtask

  task automatic test_start_err;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bit(1'b1);
    wait_cyc(4);
    total++;
    if (err_cnt !== e0 + 1 || valid_cnt !== v0) begin
      bad++;
      $display("FAIL start_bit_err: err=%0d valid=%0d want 1/0", err_cnt - e0, valid_cnt - v0);
    end
    key_event(1'b0, 1'b1, 8'h29);
    total++;
    if (p1_shoot !== 1'b0) begin
      bad++;
      $display("FAIL shoot_release: shoot=%b want=0", p1_shoot);
    end
  endtask

  task automatic test_timeout;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    wait_cyc(TO - 30);
    total++;
    if (err_cnt !== e0) begin
      bad++;
      $display("FAIL timeout_early: err=%0d want=0", err_cnt - e0);
    end
    wait_cyc(40);
    total++;
    if (err_cnt !== e0 + 1 || valid_cnt !== v0 || outs !== exp_outs(model_held)) begin
      bad++;
      $display("FAIL timeout: err=%0d valid=%0d outs=%b want 1/0/%b", err_cnt - e0, valid_cnt - v0, outs, exp_outs(model_held));
    end
    key_event(1'b0, 1'b0, 8'h5A);
    total++;
    if (p2_shoot !== 1'b1) begin
      bad++;
      $display("FAIL after_timeout: p2_shoot=%b want=1", p2_shoot);
    end
  endtask

  task automatic test_random;
    int k, v0, nb;
    logic ext, brk;
    for (int n = 0; n < 40; n++) begin
      k   = int'($urandom_range(0, 9));
      brk = 1'($urandom_range(0, 1));
      ext = key_ext[k];
      if (ext && $urandom_range(0, 4) == 0) ext = 1'b0;
      nb  = 1 + int'(ext) + int'(brk);
      v0  = valid_cnt;
      key_event(ext, brk, key_code[k]);
      total++;
      if (valid_cnt !== v0 + nb || snap1 !== prev_exp || snap2 !== exp_outs(model_held)) begin
        bad++;
        $display("FAIL random_%0d: valids=%0d s1=%b s2=%b want %0d/%b/%b", n, valid_cnt - v0, snap1, snap2, nb, prev_exp, exp_outs(model_held));
      end
    end
  endtask

  task automatic test_reset_mid;
    key_event(1'b0, 1'b0, 8'h1D);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_i = 1'b1;
    wait_cyc(1);
    total++;
    if ({outs, scancode, scancode_valid, frame_error} !== 20'd0) begin
      bad++;
      $display("FAIL reset_mid: got=%h want=0", {outs, scancode, scancode_valid, frame_error});
    end
    reset_i = 1'b0;
    model_held = '0;
    wait_cyc(5);
    key_event(1'b0, 1'b0, 8'h1B);
    total++;
    if (p1_move !== 4'b0001 || outs !== exp_outs(model_held)) begin
      bad++;
      $display("FAIL after_reset_mid: p1=%b want=0001", p1_move);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_extended();
    test_cancel();
    test_parity();
    test_start_err();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
